// File: rtl/mnist_frame_feeder.sv
// Ping-pong frame buffer between the host byte stream and the CNN pixel input.
// Optional WAIT_RES watchdog is enabled by defining FEEDER_TIMEOUT_EN.
module mnist_frame_feeder #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int PIX_W       = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [PIX_W-1:0] pixel_o,
    output logic             pixel_o_valid,
    input  logic             digit_i_valid,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output logic             err_spurious,
    output logic             timeout_err
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);
    localparam logic [AW:0]   BANK1_BASE = (AW + 1)'(N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 16-bit watchdog counter");
    end

    logic [PIX_W-1:0] mem [0:2*N-1];
    logic [1:0]       state;
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [AW:0]      wr_idx;
    logic [AW:0]      rd_idx;
    logic             accept;
    logic             stream_last;

    // Gated by rst so every output reads 0 while reset is held.
    assign s_ready     = !rst && !bank_full[wr_bank];
    assign accept      = s_valid && s_ready;
    assign stream_last = (state == S_STREAM) && (rd_addr == LAST_ADDR);
    assign busy        = (state != S_IDLE);
    assign wr_idx      = wr_bank ? BANK1_BASE + {1'b0, wr_addr} : {1'b0, wr_addr};
    assign rd_idx      = rd_bank ? BANK1_BASE + {1'b0, rd_addr} : {1'b0, rd_addr};

    // Fill and free always target different banks, so both may land in one cycle.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        bank_full_nxt = bank_full;
        if (accept && wr_addr == LAST_ADDR) bank_full_nxt[wr_bank] = 1'b1;
        if (stream_last)                    bank_full_nxt[rd_bank] = 1'b0;
    end

    // NOTE: frame storage has no reset; the bank_full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_idx] <= s_data;
    end

`ifdef FEEDER_TIMEOUT_EN
    logic [15:0] wd_cnt;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
`else
    assign timeout_err = 1'b0;
`endif

    // NOTE: non-blocking assignments for all registered state so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bank_full     <= 2'b00;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            pixel_o       <= '0;
            pixel_o_valid <= 1'b0;
            frame_cnt     <= 16'd0;
            err_spurious  <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            wd_cnt        <= 16'd0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            bank_full     <= bank_full_nxt;
            pixel_o_valid <= (state == S_STREAM);
            if (state == S_STREAM) pixel_o <= mem[rd_idx];
`ifdef FEEDER_TIMEOUT_EN
            timeout_err   <= 1'b0;
`endif

            if (accept) begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end

            if (digit_i_valid && state != S_WAIT) err_spurious <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (bank_full[rd_bank]) begin
                        rd_addr <= '0;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (stream_last) begin
                        rd_bank <= ~rd_bank;
                        state   <= S_WAIT;
`ifdef FEEDER_TIMEOUT_EN
                        wd_cnt  <= 16'd0;
`endif
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (digit_i_valid) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= S_IDLE;
`ifdef FEEDER_TIMEOUT_EN
                    end else if (wd_cnt == WD_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
